gs_div_issue_queue: RTL and testbench

//  Upstream feeder for the Goldschmidt FP32 divider (goldSmithDiv).
//  - Buffers {dividend, divisor} pairs arriving on a valid/ready stream.
//  - Issues them to the divider one at a time, with a 1-cycle start pulse.
//  - Waits a fixed latency, captures the quotient and returns it on a valid/ready result stream.
//  - Divide-by-zero operands bypass the divider.

---
 rtl/gs_div_pkg.sv | 32 +++
 rtl/gs_div_issue_queue_if.sv | 33 +++
 rtl/gs_div_operand_fifo.sv | 68 ++++++
 rtl/gs_div_issue_queue.sv | 124 ++++++++++++
 tb/tb_gs_div_issue_queue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gs_div_pkg.sv
// Shared types and constants for the Goldschmidt divider issue queue.
//   FP_W/EXP_W/FRAC_W : IEEE-754 single-precision field widths
//   EXP_INF           : all-ones exponent used to build a signed infinity
//   div_req_t         : one {dividend, divisor} operand pair
//   issue_state_t     : issue FSM states
//   is_zero()         : true for +0 / -0 (exponent and fraction all zero)
package gs_div_pkg;

   localparam int unsigned FP_W    = 32;
   localparam int unsigned EXP_W   = 8;
   localparam int unsigned FRAC_W  = 23;
   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

   typedef struct packed {
      logic [FP_W-1:0] dividend;
      logic [FP_W-1:0] divisor;
   } div_req_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      BYPASS = 3'd3,
      HOLD   = 3'd4
   } issue_state_t;

   // Sign bit is ignored: both +0 and -0 take the bypass path.
   function automatic logic is_zero(input logic [FP_W-1:0] v);
      return (v[FP_W-2:0] == (FP_W-1)'(0));
   endfunction

endpackage

// File: rtl/gs_div_issue_queue_if.sv
// Bundles the operand stream, divider handshake and result stream.
//   in_*   : operand pair stream (valid/ready), toward the queue
//   div_*  : start pulse + held operands to the divider, quotient back
//   res_*  : quotient stream (valid/ready) plus divide-by-zero flag
// slave  = the issue queue, master = whoever drives operands/consumes results.
interface gs_div_issue_queue_if #(parameter int unsigned W = 32);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_dividend;
   logic [W-1:0] in_divisor;
   logic         div_start;
   logic [W-1:0] div_dividend;
   logic [W-1:0] div_divisor;
   logic [W-1:0] div_out;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_dz;

   modport slave (
      input  in_valid, in_dividend, in_divisor, div_out, res_ready,
      output in_ready, div_start, div_dividend, div_divisor,
             res_valid, res_data, res_dz
   );

   modport master (
      output in_valid, in_dividend, in_divisor, div_out, res_ready,
      input  in_ready, div_start, div_dividend, div_divisor,
             res_valid, res_data, res_dz
   );

endinterface

// File: rtl/gs_div_operand_fifo.sv
// Synchronous FIFO of operand pairs.
//   clk, reset : clock, synchronous active-low reset
//   push_i     : write request (ignored while ready_o is low)
//   wdata_i    : pair to write
//   pop_i      : read request (ignored while empty_o is high)
//   rdata_o    : head entry (valid while empty_o is low)
//   ready_o    : registered "not full"; low during reset
//   empty_o    : FIFO holds no entries
module gs_div_operand_fifo
   import gs_div_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push_i,
   input  div_req_t wdata_i,
   input  logic     pop_i,
   output div_req_t rdata_o,
   output logic     ready_o,
   output logic     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   div_req_t      mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          ready_q;
   logic          do_push_c;
   logic          do_pop_c;
   logic          full_d;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign do_push_c = push_i && ready_q;
   assign do_pop_c  = pop_i && !empty_o;
   assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
   assign ready_o   = ready_q;

   // Next pointers; ready is registered from the post-update fullness.
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push_c);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop_c);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   // Pointers and ready flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ready_q  <= !full_d;
      end
   end

   // Storage needs no reset; only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/gs_div_issue_queue.sv
// Upstream feeder for the Goldschmidt FP32 divider: queues operand pairs,
// issues one at a time with a 1-cycle start pulse, waits DIV_LATENCY cycles,
// captures the quotient and presents it on a valid/ready result stream.
// Divisors of +-0 bypass the divider and return a signed infinity.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : operand stream, divider handshake and result stream (slave side)
module gs_div_issue_queue
   import gs_div_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned DIV_LATENCY = 8,
   parameter int unsigned W           = FP_W
) (
   input  logic                  clk,
   input  logic                  reset,
   gs_div_issue_queue_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

   issue_state_t  state_q;
   logic [CNT_W-1:0] cnt_q;
   logic          div_start_q;
   logic [W-1:0]  div_dividend_q;
   logic [W-1:0]  div_divisor_q;
   logic          res_valid_q;
   logic [W-1:0]  res_data_q;
   logic          res_dz_q;

   div_req_t      req_in_c;
   div_req_t      head_c;
   logic          fifo_ready_c;
   logic          fifo_empty_c;
   logic          pop_c;

   always_comb begin
      req_in_c          = '0;
      req_in_c.dividend = bus.in_dividend;
      req_in_c.divisor  = bus.in_divisor;
   end

   // Pop only while idle, so at most one op is ever outstanding.
   assign pop_c = (state_q == IDLE) && !fifo_empty_c;

   gs_div_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.in_valid),
      .wdata_i (req_in_c),
      .pop_i   (pop_c),
      .rdata_o (head_c),
      .ready_o (fifo_ready_c),
      .empty_o (fifo_empty_c)
   );

   // Issue FSM, latency counter and result register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         div_start_q    <= 1'b0;
         div_dividend_q <= '0;
         div_divisor_q  <= '0;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
         res_dz_q       <= 1'b0;
      end else begin
         div_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty_c) begin
                  div_dividend_q <= head_c.dividend;
                  div_divisor_q  <= head_c.divisor;
                  if (is_zero(head_c.divisor)) begin
                     state_q <= BYPASS;
                  end else begin
                     // Start pulse lands exactly on the ISSUE cycle.
                     div_start_q <= 1'b1;
                     state_q     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt_q   <= CNT_W'(1);
               state_q <= WAIT;
            end
            WAIT: begin
               if (cnt_q == CNT_W'(DIV_LATENCY)) begin
                  res_data_q  <= bus.div_out;
                  res_dz_q    <= 1'b0;
                  res_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            BYPASS: begin
               res_data_q  <= {div_dividend_q[W-1] ^ div_divisor_q[W-1],
                               EXP_INF, FRAC_W'(0)};
               res_dz_q    <= 1'b1;
               res_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready     = fifo_ready_c;
   assign bus.div_start    = div_start_q;
   assign bus.div_dividend = div_dividend_q;
   assign bus.div_divisor  = div_divisor_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_dz       = res_dz_q;

endmodule

// File: tb/tb_gs_div_issue_queue.sv
// Self-checking bench for gs_div_issue_queue with a fixed-latency divider model.
module tb_gs_div_issue_queue;
   import gs_div_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT   = 8;

   typedef struct {
      logic [31:0] data;
      logic        dz;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   gs_div_issue_queue_if #(.W(32)) bus ();

   gs_div_issue_queue #(.DEPTH(DEPTH), .DIV_LATENCY(LAT), .W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc          = 0;
   int   starts       = 0;
   int   dbl_starts   = 0;
   int   m_cnt        = 0;
   logic prev_start   = 1'b0;
   logic [31:0] m_q   = '0;
   int   last_accept_cyc = 0;
   exp_t exp_q [$];

   // Synthetic quotient: exact for 6.0/2.0, an arbitrary operand hash otherwise.
   function automatic logic [31:0] model_quot(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h0055_AA00;
   endfunction

   function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      if (b[30:0] == 31'd0) begin
         e.data = {a[31] ^ b[31], 8'hFF, 23'h0};
         e.dz   = 1'b1;
      end else begin
         e.data = model_quot(a, b);
         e.dz   = 1'b0;
      end
      return e;
   endfunction

   // Divider model: quotient only appears on the single cycle it is due.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         m_cnt      <= 0;
         prev_start <= 1'b0;
      end else begin
         prev_start <= bus.div_start;
         if (bus.div_start) begin
            m_cnt  <= 1;
            m_q    <= model_quot(bus.div_dividend, bus.div_divisor);
            starts <= starts + 1;
            if (prev_start) dbl_starts <= dbl_starts + 1;
         end else if (m_cnt != 0 && m_cnt < int'(LAT)) begin
            m_cnt <= m_cnt + 1;
         end else begin
            m_cnt <= 0;
         end
      end
   end

   assign bus.div_out = (m_cnt == int'(LAT)) ? m_q : 32'hDEAD_BEEF;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Hold a pair on the input until accepted; queue its expected result.
   task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      bus.in_valid    = 1'b1;
      bus.in_dividend = a;
      bus.in_divisor  = b;
      while (!bus.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         tests_run++;
         tests_failed++;
         $display("FAIL push_timeout: pair %h/%h never accepted", a, b);
         bus.in_valid = 1'b0;
         return;
      end
      exp_q.push_back(expect_of(a, b));
      @(negedge clk);
      bus.in_valid    = 1'b0;
      last_accept_cyc = cyc;
   endtask

   task automatic wait_valid(output bit ok);
      int k = 0;
      while (!bus.res_valid && k < 500) begin
         @(negedge clk);
         k++;
      end
      ok = (k < 500);
      if (!ok) begin
         tests_run++;
         tests_failed++;
         $display("FAIL result_timeout: res_valid never rose");
      end
   endtask

   // Accept n results, popping the scoreboard for each.
   task automatic collect(input int n);
      bit   ok;
      exp_t e;
      bus.res_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         wait_valid(ok);
         if (!ok) break;
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_result: got %h dz=%b, none expected",
                     bus.res_data, bus.res_dz);
         end else begin
            e = exp_q.pop_front();
            if (bus.res_data !== e.data || bus.res_dz !== e.dz) begin
               tests_failed++;
               $display("FAIL result[%0d]: got %h dz=%b, expected %h dz=%b",
                        i, bus.res_data, bus.res_dz, e.data, e.dz);
            end
         end
         @(negedge clk);
      end
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.div_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: in_ready=%b res_valid=%b div_start=%b, expected 0 0 0",
                  bus.in_ready, bus.res_valid, bus.div_start);
      end
      tests_run++;
      if (bus.div_dividend !== 32'h0 || bus.div_divisor !== 32'h0 ||
          bus.res_data !== 32'h0 || bus.res_dz !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_data: dvd=%h dvs=%h res=%h dz=%b, expected zeros",
                  bus.div_dividend, bus.div_divisor, bus.res_data, bus.res_dz);
      end
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: in_ready=%b, expected 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int s0 = starts;
      drive_pair(32'h40C0_0000, 32'h4000_0000);
      wait_valid(ok);
      if (ok) begin
         tests_run++;
         // push edge -> pop edge (1) + ISSUE (1) + DIV_LATENCY
         if (cyc - last_accept_cyc != int'(LAT) + 2) begin
            tests_failed++;
            $display("FAIL basic_latency: %0d cycles push->valid, expected %0d",
                     cyc - last_accept_cyc, LAT + 2);
         end
      end
      collect(1);
      tests_run++;
      if (starts - s0 != 1) begin
         tests_failed++;
         $display("FAIL basic_starts: %0d start pulses, expected 1", starts - s0);
      end
   endtask

   task automatic test_bypass();
      bit ok;
      int s0 = starts;
      logic [31:0] da [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000};
      logic [31:0] db [3] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
      for (int i = 0; i < 3; i++) begin
         drive_pair(da[i], db[i]);
         wait_valid(ok);
         if (ok) begin
            tests_run++;
            if (cyc - last_accept_cyc != 2) begin
               tests_failed++;
               $display("FAIL bypass_latency[%0d]: %0d cycles push->valid, expected 2",
                        i, cyc - last_accept_cyc);
            end
         end
         collect(1);
      end
      tests_run++;
      if (starts != s0) begin
         tests_failed++;
         $display("FAIL bypass_starts: %0d start pulses, expected 0", starts - s0);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] pa [6] = '{32'h3F80_0000, 32'h4120_0000, 32'hC040_0000,
                              32'h4000_0000, 32'h3F00_0000, 32'h4296_0000};
      logic [31:0] pb [6] = '{32'h4040_0000, 32'h0000_0000, 32'h3FC0_0000,
                              32'h4080_0000, 32'hC100_0000, 32'h40A0_0000};
      bit stalled = 1'b0;
      bus.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) drive_pair(pa[i], pb[i]);
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_full: in_ready=%b after 5 pushes, expected 0", bus.in_ready);
      end
      bus.in_valid    = 1'b1;
      bus.in_dividend = pa[5];
      bus.in_divisor  = pb[5];
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0) stalled = 1'b1;
      end
      tests_run++;
      if (stalled) begin
         tests_failed++;
         $display("FAIL bp_stall: in_ready rose while full with res_ready=0, expected 0");
      end
      fork
         drive_pair(pa[5], pb[5]);
         collect(6);
      join
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL bp_drain: %0d results missing, expected 0", exp_q.size());
      end
   endtask

   task automatic test_push_pop();
      bit ok;
      exp_t e;
      logic [2:0] cnt;
      bus.res_ready = 1'b0;
      drive_pair(32'h4100_0000, 32'h4000_0000);
      drive_pair(32'h4180_0000, 32'h4040_0000);
      drive_pair(32'h4200_0000, 32'hC080_0000);
      wait_valid(ok);
      if (ok) begin
         tests_run++;
         e = exp_q.pop_front();
         if (bus.res_data !== e.data || bus.res_dz !== e.dz) begin
            tests_failed++;
            $display("FAIL pp_first: got %h dz=%b, expected %h dz=%b",
                     bus.res_data, bus.res_dz, e.data, e.dz);
         end
         bus.res_ready = 1'b1;
         @(negedge clk);
         bus.res_ready   = 1'b0;
         // FSM is now IDLE with 2 queued: the next edge pops and pushes together.
         bus.in_valid    = 1'b1;
         bus.in_dividend = 32'h4280_0000;
         bus.in_divisor  = 32'h4100_0000;
         exp_q.push_back(expect_of(32'h4280_0000, 32'h4100_0000));
         @(negedge clk);
         bus.in_valid = 1'b0;
         cnt = dut.u_fifo.wr_ptr_q - dut.u_fifo.rd_ptr_q;
         tests_run++;
         if (cnt !== 3'd2 || dut.state_q !== ISSUE) begin
            tests_failed++;
            $display("FAIL pp_count: count=%0d state=%0d, expected count=2 state=%0d",
                     cnt, dut.state_q, ISSUE);
         end
      end
      collect(3);
   endtask

   task automatic test_reset_mid_wait();
      int  k = 0;
      int  s0;
      bit  seen = 1'b0;
      drive_pair(32'h40A0_0000, 32'h4040_0000);
      while (dut.cnt_q != 4'd4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      tests_run++;
      if (k >= 100) begin
         tests_failed++;
         $display("FAIL rst_wait_timeout: counter never reached 4");
      end
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.div_dividend !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_mid: in_ready=%b res_valid=%b dvd=%h, expected 0 0 0",
                  bus.in_ready, bus.res_valid, bus.div_dividend);
      end
      reset = 1'b1;
      exp_q.delete();
      s0 = starts;
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_ready: in_ready=%b, expected 1", bus.in_ready);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.res_valid !== 1'b0 || bus.div_start !== 1'b0) seen = 1'b1;
      end
      tests_run++;
      if (seen || starts != s0) begin
         tests_failed++;
         $display("FAIL rst_mid_drop: activity after reset (res_valid/div_start seen=%b), expected none",
                  seen);
      end
   endtask

   task automatic test_stability();
      bit ok;
      int s0 = starts;
      exp_t e;
      bus.res_ready = 1'b0;
      drive_pair(32'hC2C8_0000, 32'h4120_0000);
      e = exp_q[0];
      wait_valid(ok);
      if (ok) begin
         for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== e.data ||
                bus.div_dividend !== 32'hC2C8_0000 || bus.div_divisor !== 32'h4120_0000) begin
               tests_failed++;
               $display("FAIL hold[%0d]: v=%b res=%h dvd=%h dvs=%h, expected 1 %h c2c80000 41200000",
                        i, bus.res_valid, bus.res_data, bus.div_dividend, bus.div_divisor, e.data);
            end
            @(negedge clk);
         end
      end
      collect(1);
      tests_run++;
      if (starts - s0 != 1 || dbl_starts != 0) begin
         tests_failed++;
         $display("FAIL start_once: %0d pulses (%0d doubled), expected 1 (0)",
                  starts - s0, dbl_starts);
      end
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_dividend = '0;
      bus.in_divisor  = '0;
      bus.res_ready   = 1'b0;
      test_reset();
      test_basic();
      test_bypass();
      test_backpressure();
      test_push_pop();
      test_reset_mid_wait();
      test_stability();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
